bcp_engine: RTL and testbench

- Responder side of the control/BCP handshake.
- Accepts clause indices streamed by control (bcp_en, bcp_clause_idx), reads each clause from the clause database, and evaluates its literals against the var state table, one literal per read.
- Pushes unit implications into the imply queue and raises a sticky conflict.
- Reports bcp_busy until every accepted clause is resolved.

---
 rtl/bcp_engine_pkg.sv | 40 ++++
 rtl/bcp_engine_req_fifo.sv | 69 ++++++
 rtl/bcp_engine.sv | 200 ++++++++++++++++++++
 tb/tb_bcp_engine.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcp_engine_pkg.sv
// Shared definitions for the BCP responder: literal packing and FSM state encoding.
// A literal slot is {valid, pol, var} with var in the LSBs.
package bcp_engine_pkg;

   localparam int MAX_CLAUSES_BITS = 8;
   localparam int MAX_VARS_BITS    = 6;

   localparam int LIT_W         = MAX_VARS_BITS + 2;
   localparam int LIT_VAR_LSB   = 0;
   localparam int LIT_POL_BIT   = MAX_VARS_BITS;
   localparam int LIT_VALID_BIT = MAX_VARS_BITS + 1;

   typedef logic [MAX_CLAUSES_BITS-1:0] clause_idx_t;
   typedef logic [MAX_VARS_BITS-1:0]    var_t;

   typedef struct packed {
      logic valid;
      logic pol;
      var_t var_id;
   } lit_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LIT_REQ,
      S_LIT_EVAL,
      S_RESOLVE,
      S_PUSH,
      S_HALT
   } bcp_state_e;

   function automatic lit_t unpack_lit(input logic [LIT_W-1:0] raw);
      lit_t l;
      l.valid  = raw[LIT_VALID_BIT];
      l.pol    = raw[LIT_POL_BIT];
      l.var_id = raw[LIT_VAR_LSB +: MAX_VARS_BITS];
      return l;
   endfunction

endpackage

// File: rtl/bcp_engine_req_fifo.sv
// Clause-index request FIFO: synchronous flush, simultaneous push/pop accepted when full.
// DEPTH must be a power of two so the pointers wrap naturally.
module bcp_req_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push;
   logic          do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign dout    = mem_q[rd_ptr_q];
   assign do_pop  = pop && !empty && !flush;
   // A pop in the same cycle frees the slot the push lands in.
   assign do_push = push && (!full || do_pop) && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/bcp_engine.sv
// BCP responder: fetches queued clauses, evaluates literals one var-state read at a time,
// pushes unit implications and raises a sticky conflict.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   S_IDLE     | waiting; pops FIFO head and strobes the clause read
//   S_FETCH    | clause word arrives, latched; slot and unassigned count reset
//   S_LIT_REQ  | issue var-state read for current slot, or skip padding
//   S_LIT_EVAL | var state arrives; true literal exits early
//   S_RESOLVE  | 0 unassigned -> conflict, 1 -> push, 2+ -> done
//   S_PUSH     | wait for room in the imply queue, then push
//   S_HALT     | conflict held; requests dropped until reset_bcp
module bcp_engine
   import bcp_engine_pkg::*;
#(
   parameter int LITS_PER_CLAUSE = 3,
   parameter int REQ_DEPTH       = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               bcp_en,
   input  logic [MAX_CLAUSES_BITS-1:0]        bcp_clause_idx,
   input  logic                               reset_bcp,
   output logic                               bcp_busy,
   output logic                               conflict,
   output logic                               bcp_overflow,
   output logic                               clause_rd_en,
   output logic [MAX_CLAUSES_BITS-1:0]        clause_rd_idx,
   input  logic [LITS_PER_CLAUSE*LIT_W-1:0]   clause_lits,
   output logic                               vs_rd_en,
   output logic [MAX_VARS_BITS-1:0]           vs_var,
   input  logic                               vs_val,
   input  logic                               vs_unassign,
   input  logic                               full_imply,
   output logic                               push_imply,
   output logic [MAX_VARS_BITS-1:0]           var_in_imply,
   output logic                               val_in_imply,
   output logic                               type_in_imply,
   output bcp_state_e                         bcp_state_out
);

   localparam int KW = (LITS_PER_CLAUSE > 1) ? $clog2(LITS_PER_CLAUSE) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(LITS_PER_CLAUSE - 1);

   bcp_state_e                       state_q, state_d;
   logic [KW-1:0]                    k_q, k_d;
   logic [1:0]                       cnt_q, cnt_d;
   logic [LITS_PER_CLAUSE*LIT_W-1:0] lits_q, lits_d;
   var_t                             rec_var_q, rec_var_d;
   logic                             rec_pol_q, rec_pol_d;
   logic                             conflict_q, conflict_d;
   logic                             overflow_q, overflow_d;
   logic                             push_q, push_d;

   lit_t        cur_lit;
   logic        lit_true;
   logic        fifo_pop;
   logic        fifo_flush;
   logic        req_accept;
   logic        fifo_full;
   logic        fifo_empty;
   clause_idx_t fifo_head;

   bcp_req_fifo #(
      .DEPTH (REQ_DEPTH),
      .W     (MAX_CLAUSES_BITS)
   ) u_req_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (fifo_flush),
      .push  (req_accept),
      .din   (bcp_clause_idx),
      .pop   (fifo_pop),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      cur_lit = '0;
      for (int i = 0; i < LITS_PER_CLAUSE; i++) begin
         if (k_q == KW'(i)) cur_lit = unpack_lit(lits_q[i*LIT_W +: LIT_W]);
      end
   end

   assign lit_true   = !vs_unassign && (vs_val == cur_lit.pol);
   assign fifo_pop   = (state_q == S_IDLE) && !fifo_empty && !reset_bcp;
   // HALT drops requests silently; they never count as overflow.
   assign req_accept = bcp_en && !reset_bcp && (state_q != S_HALT);
   assign fifo_flush = reset_bcp || (state_q == S_HALT);

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      cnt_d      = cnt_q;
      lits_d     = lits_q;
      rec_var_d  = rec_var_q;
      rec_pol_d  = rec_pol_q;
      conflict_d = conflict_q;
      push_d     = 1'b0;
      overflow_d = overflow_q | (req_accept & fifo_full & ~fifo_pop);

      case (state_q)
         S_IDLE: begin
            if (fifo_pop) state_d = S_FETCH;
         end
         S_FETCH: begin
            lits_d  = clause_lits;
            k_d     = '0;
            cnt_d   = '0;
            state_d = S_LIT_REQ;
         end
         S_LIT_REQ: begin
            if (cur_lit.valid)     state_d = S_LIT_EVAL;
            else if (k_q == K_LAST) state_d = S_RESOLVE;
            else                    k_d     = k_q + 1'b1;
         end
         S_LIT_EVAL: begin
            if (lit_true) begin
               state_d = S_IDLE;
            end else begin
               if (vs_unassign) begin
                  if (cnt_q != 2'd2) cnt_d = cnt_q + 2'd1;
                  rec_var_d = cur_lit.var_id;
                  rec_pol_d = cur_lit.pol;
               end
               if (k_q == K_LAST) begin
                  state_d = S_RESOLVE;
               end else begin
                  k_d     = k_q + 1'b1;
                  state_d = S_LIT_REQ;
               end
            end
         end
         S_RESOLVE: begin
            case (cnt_q)
               2'd0: begin
                  conflict_d = 1'b1;
                  state_d    = S_HALT;
               end
               2'd1:    state_d = S_PUSH;
               default: state_d = S_IDLE;
            endcase
         end
         S_PUSH: begin
            if (!full_imply) begin
               push_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase

      if (reset_bcp) begin
         state_d    = S_IDLE;
         conflict_d = 1'b0;
         push_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         k_q        <= '0;
         cnt_q      <= '0;
         lits_q     <= '0;
         rec_var_q  <= '0;
         rec_pol_q  <= 1'b0;
         conflict_q <= 1'b0;
         overflow_q <= 1'b0;
         push_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         cnt_q      <= cnt_d;
         lits_q     <= lits_d;
         rec_var_q  <= rec_var_d;
         rec_pol_q  <= rec_pol_d;
         conflict_q <= conflict_d;
         overflow_q <= overflow_d;
         push_q     <= push_d;
      end
   end

   assign clause_rd_en  = fifo_pop;
   assign clause_rd_idx = fifo_pop ? fifo_head : '0;
   assign vs_rd_en      = (state_q == S_LIT_REQ) && cur_lit.valid;
   assign vs_var        = vs_rd_en ? cur_lit.var_id : '0;
   assign push_imply    = push_q;
   assign var_in_imply  = rec_var_q;
   assign val_in_imply  = rec_pol_q;
   assign type_in_imply = 1'b1;
   assign conflict      = conflict_q;
   assign bcp_overflow  = overflow_q;
   assign bcp_state_out = state_q;
   // Low in HALT so control observes conflict with busy deasserted.
   assign bcp_busy      = bcp_en | !fifo_empty | ((state_q != S_IDLE) && (state_q != S_HALT));

endmodule

// File: tb/tb_bcp_engine.sv
// Bench for bcp_engine: clause/var-state memory models, table vectors, corner sequences,
// and random clauses checked against a clause-level outcome model.
module tb_bcp_engine;
   import bcp_engine_pkg::*;

   localparam int LPC    = 3;
   localparam int CW     = LPC * LIT_W;
   localparam int K_SAT  = 0;
   localparam int K_UNIT = 1;
   localparam int K_CONF = 2;
   localparam int K_NONE = 3;

   logic                        clk = 1'b0;
   logic                        rst_n = 1'b0;
   logic                        bcp_en = 1'b0;
   logic [MAX_CLAUSES_BITS-1:0] bcp_clause_idx = '0;
   logic                        reset_bcp = 1'b0;
   logic                        bcp_busy, conflict, bcp_overflow;
   logic                        clause_rd_en;
   logic [MAX_CLAUSES_BITS-1:0] clause_rd_idx;
   logic [CW-1:0]               clause_lits = '0;
   logic                        vs_rd_en;
   logic [MAX_VARS_BITS-1:0]    vs_var;
   logic                        vs_val = 1'b0;
   logic                        vs_unassign = 1'b0;
   logic                        full_imply = 1'b0;
   logic                        push_imply;
   logic [MAX_VARS_BITS-1:0]    var_in_imply;
   logic                        val_in_imply, type_in_imply;
   bcp_state_e                  bcp_state_out;

   always #5 clk = ~clk;

   bcp_engine #(.LITS_PER_CLAUSE(LPC), .REQ_DEPTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .bcp_en(bcp_en), .bcp_clause_idx(bcp_clause_idx),
      .reset_bcp(reset_bcp), .bcp_busy(bcp_busy), .conflict(conflict),
      .bcp_overflow(bcp_overflow), .clause_rd_en(clause_rd_en), .clause_rd_idx(clause_rd_idx),
      .clause_lits(clause_lits), .vs_rd_en(vs_rd_en), .vs_var(vs_var), .vs_val(vs_val),
      .vs_unassign(vs_unassign), .full_imply(full_imply), .push_imply(push_imply),
      .var_in_imply(var_in_imply), .val_in_imply(val_in_imply),
      .type_in_imply(type_in_imply), .bcp_state_out(bcp_state_out)
   );

   logic [CW-1:0] clause_db [256];
   bit            var_asg [64];
   bit            var_v   [64];

   always @(posedge clk) begin
      if (clause_rd_en) clause_lits <= clause_db[clause_rd_idx];
      if (vs_rd_en) begin
         vs_val      <= var_v[vs_var];
         vs_unassign <= !var_asg[vs_var];
      end
   end

   logic [MAX_VARS_BITS-1:0]    obs_var  [64];
   bit                          obs_val  [64];
   bit                          obs_type [64];
   logic [MAX_CLAUSES_BITS-1:0] obs_idx  [64];
   int n_push = 0, n_rd = 0, n_reads = 0;

   always @(negedge clk) begin
      if (vs_rd_en) n_reads = n_reads + 1;
      if (clause_rd_en) begin
         obs_idx[n_rd % 64] = clause_rd_idx;
         n_rd = n_rd + 1;
      end
      if (push_imply) begin
         obs_var[n_push % 64]  = var_in_imply;
         obs_val[n_push % 64]  = val_in_imply;
         obs_type[n_push % 64] = type_in_imply;
         n_push = n_push + 1;
      end
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int idx);
      bcp_clause_idx = clause_idx_t'(idx);
      bcp_en = 1'b1;
      tick();
      bcp_en = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int c;
      c = 0;
      @(negedge clk);
      while (bcp_busy && c < budget) begin
         @(negedge clk);
         c++;
      end
      if (bcp_busy) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", budget);
      end
   endtask

   // st: 0 = assigned false, 1 = assigned true, 2 = unassigned
   task automatic set_var(input int v, input int st);
      var_asg[v] = (st != 2);
      var_v[v]   = (st == 1);
   endtask

   function automatic logic [LIT_W-1:0] mk_lit(input bit valid, input bit pol, input int v);
      logic [31:0] vv;
      vv = v;
      return {valid, pol, vv[MAX_VARS_BITS-1:0]};
   endfunction

   // Outcome of a clause under the current assignment, from the literal rules alone.
   task automatic model(input logic [CW-1:0] cl, output int kind, output int mvar,
                        output bit mval, output int reads);
      int nun;
      nun = 0; reads = 0; mvar = 0; mval = 1'b0; kind = K_NONE;
      for (int s = 0; s < LPC; s++) begin
         logic [LIT_W-1:0] lit;
         int v;
         lit = cl[s*LIT_W +: LIT_W];
         v = int'(lit[MAX_VARS_BITS-1:0]);
         if (lit[LIT_W-1]) begin
            reads++;
            if (var_asg[v] && (var_v[v] == lit[LIT_W-2])) begin
               kind = K_SAT;
               return;
            end
            if (!var_asg[v]) begin
               nun++;
               mvar = v;
               mval = lit[LIT_W-2];
            end
         end
      end
      kind = (nun == 0) ? K_CONF : (nun == 1) ? K_UNIT : K_NONE;
   endtask

   task automatic run_vec(input string name, input int idx, input logic [CW-1:0] cl,
                          input int kind, input int mvar, input bit mval, input int reads);
      int p0, r0;
      reset_bcp = 1'b1;
      tick();
      reset_bcp = 1'b0;
      clause_db[idx] = cl;
      p0 = n_push;
      r0 = n_reads;
      issue(idx);
      wait_idle(60);
      tick();
      tick();
      chk({name, " pushes"}, n_push - p0, (kind == K_UNIT) ? 1 : 0);
      chk({name, " conflict"}, int'(conflict), (kind == K_CONF) ? 1 : 0);
      chk({name, " vs_reads"}, n_reads - r0, reads);
      if (kind == K_UNIT && n_push > p0) begin
         chk({name, " imply_var"}, int'(obs_var[p0 % 64]), mvar);
         chk({name, " imply_val"}, int'(obs_val[p0 % 64]), int'(mval));
         chk({name, " imply_type"}, int'(obs_type[p0 % 64]), 1);
      end
   endtask

   typedef struct {
      string         name;
      int            idx;
      logic [CW-1:0] cl;
      int            st1, st2, st3;
      int            kind, mvar;
      bit            mval;
      int            reads;
   } vec_t;

   localparam logic [LIT_W-1:0] INV = '0;

   initial begin
      vec_t tbl[8];
      int p0, rd0, c;

      for (int v = 0; v < 64; v++) set_var(v, 2);
      for (int i = 0; i < 256; i++) clause_db[i] = '0;

      tbl[0] = '{"unit_x3", 5, {mk_lit(1,1,3), mk_lit(1,0,2), mk_lit(1,1,1)}, 0, 1, 2, K_UNIT, 3, 1'b1, 3};
      tbl[1] = '{"conf_2lit", 7, {INV, mk_lit(1,1,2), mk_lit(1,1,1)}, 0, 0, 2, K_CONF, 0, 1'b0, 2};
      tbl[2] = '{"sat_slot0", 2, {mk_lit(1,1,3), mk_lit(1,1,2), mk_lit(1,1,1)}, 1, 2, 2, K_SAT, 0, 1'b0, 1};
      tbl[3] = '{"two_unassigned", 9, {mk_lit(1,0,3), mk_lit(1,0,2), mk_lit(1,0,1)}, 2, 2, 1, K_NONE, 0, 1'b0, 3};
      tbl[4] = '{"unit_padded", 11, {INV, mk_lit(1,0,2), INV}, 1, 2, 1, K_UNIT, 2, 1'b0, 1};
      tbl[5] = '{"all_padding", 12, {INV, INV, INV}, 2, 2, 2, K_CONF, 0, 1'b0, 0};
      tbl[6] = '{"sat_after_u", 13, {mk_lit(1,0,3), mk_lit(1,1,2), mk_lit(1,1,1)}, 2, 1, 0, K_SAT, 0, 1'b0, 2};
      tbl[7] = '{"sat_neg_slot0", 14, {mk_lit(1,1,2), mk_lit(1,1,1), mk_lit(1,0,3)}, 0, 0, 0, K_SAT, 0, 1'b0, 1};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", int'(bcp_busy), 0);
      chk("rst conflict", int'(conflict), 0);
      chk("rst overflow", int'(bcp_overflow), 0);
      chk("rst clause_rd_en", int'(clause_rd_en), 0);
      chk("rst vs_rd_en", int'(vs_rd_en), 0);
      chk("rst push_imply", int'(push_imply), 0);
      chk("rst type_in_imply", int'(type_in_imply), 1);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         set_var(1, tbl[i].st1);
         set_var(2, tbl[i].st2);
         set_var(3, tbl[i].st3);
         run_vec(tbl[i].name, tbl[i].idx, tbl[i].cl, tbl[i].kind, tbl[i].mvar,
                 tbl[i].mval, tbl[i].reads);
      end

      // Conflict halts the engine until reset_bcp
      set_var(1, 0); set_var(2, 0);
      run_vec("halt_setup", 7, tbl[1].cl, K_CONF, 0, 1'b0, 2);
      chk("halt busy", int'(bcp_busy), 0);
      rd0 = n_rd;
      issue(2);
      issue(9);
      repeat (10) tick();
      chk("halt dropped reads", n_rd - rd0, 0);
      chk("halt conflict held", int'(conflict), 1);
      chk("halt no overflow", int'(bcp_overflow), 0);
      chk("halt busy after drop", int'(bcp_busy), 0);
      reset_bcp = 1'b1;
      bcp_en = 1'b1;
      bcp_clause_idx = 8'd2;
      tick();
      reset_bcp = 1'b0;
      bcp_en = 1'b0;
      chk("reset_bcp clears conflict", int'(conflict), 0);
      repeat (4) tick();
      chk("reset_bcp ignores bcp_en", n_rd - rd0, 0);
      chk("reset_bcp busy", int'(bcp_busy), 0);

      // Unit clause stalled on a full imply queue
      set_var(1, 0); set_var(2, 1); set_var(3, 2);
      clause_db[5] = tbl[0].cl;
      full_imply = 1'b1;
      p0 = n_push;
      issue(5);
      repeat (14) @(negedge clk);
      chk("stall no push", n_push - p0, 0);
      chk("stall busy", int'(bcp_busy), 1);
      chk("stall var held", int'(var_in_imply), 3);
      chk("stall val held", int'(val_in_imply), 1);
      tick();
      full_imply = 1'b0;
      @(negedge clk);
      chk("stall push not yet", int'(push_imply), 0);
      @(negedge clk);
      chk("stall push after release", int'(push_imply), 1);
      chk("stall push var", int'(var_in_imply), 3);
      chk("stall push val", int'(val_in_imply), 1);
      chk("stall push type", int'(type_in_imply), 1);
      @(negedge clk);
      chk("stall push one cycle", int'(push_imply), 0);
      chk("stall busy drop", int'(bcp_busy), 0);
      chk("stall push count", n_push - p0, 1);

      // Random clauses against the outcome model
      for (int it = 0; it < 40; it++) begin
         logic [CW-1:0] cl;
         int kind, mv, rd;
         bit mval;
         for (int v = 0; v < 16; v++) set_var(v, int'($urandom_range(0, 2)));
         cl = '0;
         for (int s = 0; s < LPC; s++)
            cl[s*LIT_W +: LIT_W] = mk_lit($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                                          int'($urandom_range(0, 15)));
         model(cl, kind, mv, mval, rd);
         run_vec("random", 100 + it, cl, kind, mv, mval, rd);
      end

      // Ten back-to-back requests behind a slow clause overflow the 8-deep FIFO
      set_var(4, 2); set_var(5, 2); set_var(6, 2);
      for (int i = 20; i < 30; i++) clause_db[i] = {mk_lit(1,0,6), mk_lit(1,0,5), mk_lit(1,0,4)};
      reset_bcp = 1'b1;
      tick();
      reset_bcp = 1'b0;
      rd0 = n_rd;
      for (int i = 0; i < 10; i++) begin
         bcp_en = 1'b1;
         bcp_clause_idx = clause_idx_t'(20 + i);
         tick();
      end
      bcp_en = 1'b0;
      wait_idle(200);
      tick();
      tick();
      chk("overflow set", int'(bcp_overflow), 1);
      chk("overflow accepted count", n_rd - rd0, 9);
      for (int i = 0; i < 9; i++)
         chk("overflow fifo order", int'(obs_idx[(rd0 + i) % 64]), 20 + i);

      // Asynchronous reset while a literal is being evaluated
      set_var(1, 0); set_var(2, 1); set_var(3, 2);
      reset_bcp = 1'b1;
      tick();
      reset_bcp = 1'b0;
      p0 = n_push;
      issue(5);
      c = 0;
      @(negedge clk);
      while (!vs_rd_en && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk("areset saw vs read", int'(vs_rd_en), 1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("areset busy", int'(bcp_busy), 0);
      chk("areset conflict", int'(conflict), 0);
      chk("areset overflow", int'(bcp_overflow), 0);
      chk("areset clause_rd_en", int'(clause_rd_en), 0);
      chk("areset vs_rd_en", int'(vs_rd_en), 0);
      chk("areset push_imply", int'(push_imply), 0);
      chk("areset type", int'(type_in_imply), 1);
      tick();
      tick();
      rst_n = 1'b1;
      rd0 = n_rd;
      repeat (15) tick();
      chk("areset no push", n_push - p0, 0);
      chk("areset fifo empty busy", int'(bcp_busy), 0);
      chk("areset no clause read", n_rd - rd0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
